// File: rtl/bp_pkg.sv
// Shared branch-prediction types: pipeline width, resolve FSM states,
// mispredict classes and the BTB write-port bundle.
package bp_pkg;

   localparam int XLEN = 32;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SHADOW = 1'b1
   } resolve_state_e;

   typedef enum logic [1:0] {
      MP_NONE   = 2'd0,
      MP_DIR_NT = 2'd1,
      MP_DIR_T  = 2'd2,
      MP_TGT    = 2'd3
   } mispredict_e;

   typedef struct packed {
      logic            en;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
   } btb_update_t;

endpackage

// File: rtl/branch_resolve_if.sv
// EX-side bundle into the branch resolver plus its redirect, BTB-write and
// performance-counter outputs.
interface branch_resolve_if
   import bp_pkg::*;
#(
   parameter int CNT_W = 32
) ();

   logic            ex_valid;
   logic            ex_stall;
   logic            ex_is_branch;
   logic            ex_is_jump;
   logic [XLEN-1:0] ex_pc;
   logic            ex_pred_hit;
   logic [XLEN-1:0] ex_pred_target;
   logic            ex_taken;
   logic [XLEN-1:0] ex_target;

   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             btb_update_en;
   logic [XLEN-1:0]  btb_update_pc;
   logic [XLEN-1:0]  btb_update_target;
   logic [CNT_W-1:0] cnt_branches;
   logic [CNT_W-1:0] cnt_mispredicts;

   modport master (
      output ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_pc,
             ex_pred_hit, ex_pred_target, ex_taken, ex_target,
      input  redirect_valid, redirect_pc, btb_update_en, btb_update_pc,
             btb_update_target, cnt_branches, cnt_mispredicts
   );

   modport slave (
      input  ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_pc,
             ex_pred_hit, ex_pred_target, ex_taken, ex_target,
      output redirect_valid, redirect_pc, btb_update_en, btb_update_pc,
             btb_update_target, cnt_branches, cnt_mispredicts
   );

endinterface

// File: rtl/perf_counter.sv
// Free-running wrapping event counter with an increment enable.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        count_q <= '0;
      else if (inc_i) count_q <= count_q + 1'b1;
   end

   assign count_o = count_q;

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolver: compares the carried prediction with the resolved
// outcome, issues a registered redirect and BTB write, then masks the flush shadow.
module branch_resolve
   import bp_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input logic             clk,
   input logic             rst,
   branch_resolve_if.slave bus
);

   localparam int SH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   resolve_state_e  state_q, state_d;
   logic [SH_W-1:0] shadow_cnt_q, shadow_cnt_d;
   logic            redirect_valid_q;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   btb_update_t     btb_q, btb_d;

   logic        resolve;
   logic        act_taken;
   logic        mispredict;
   mispredict_e mp_class;

   assign resolve = bus.ex_valid && !bus.ex_stall &&
                    (bus.ex_is_branch || bus.ex_is_jump) && (state_q == RUN);

   // A jump flag overrides the direction input, even if ex_is_branch is also set.
   assign act_taken = bus.ex_is_jump | bus.ex_taken;

   always_comb begin
      mp_class = MP_NONE;
      if (bus.ex_pred_hit && !act_taken)
         mp_class = MP_DIR_NT;
      else if (!bus.ex_pred_hit && act_taken)
         mp_class = MP_DIR_T;
      else if (bus.ex_pred_hit && act_taken && (bus.ex_pred_target != bus.ex_target))
         mp_class = MP_TGT;
   end

   assign mispredict = resolve && (mp_class != MP_NONE);

   always_comb begin
      redirect_pc_d = redirect_pc_q;
      if (mispredict)
         redirect_pc_d = (mp_class == MP_DIR_NT) ? bus.ex_pc + 32'd4 : bus.ex_target;
   end

   // Payload holds its last value; only the strobe pulses.
   always_comb begin
      btb_d    = btb_q;
      btb_d.en = 1'b0;
      if (resolve && act_taken &&
          (!bus.ex_pred_hit || (bus.ex_pred_target != bus.ex_target))) begin
         btb_d.en     = 1'b1;
         btb_d.pc     = bus.ex_pc;
         btb_d.target = bus.ex_target;
      end
   end

   always_comb begin
      state_d      = state_q;
      shadow_cnt_d = shadow_cnt_q;
      case (state_q)
         RUN: begin
            if (mispredict) begin
               state_d      = SHADOW;
               shadow_cnt_d = SH_W'(FLUSH_CYCLES - 1);
            end
         end
         SHADOW: begin
            if (shadow_cnt_q == '0) state_d = RUN;
            else                    shadow_cnt_d = shadow_cnt_q - 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= RUN;
         shadow_cnt_q     <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         btb_q            <= '0;
      end else begin
         state_q          <= state_d;
         shadow_cnt_q     <= shadow_cnt_d;
         redirect_valid_q <= mispredict;
         redirect_pc_q    <= redirect_pc_d;
         btb_q            <= btb_d;
      end
   end

   assign bus.redirect_valid    = redirect_valid_q;
   assign bus.redirect_pc       = redirect_pc_q;
   assign bus.btb_update_en     = btb_q.en;
   assign bus.btb_update_pc     = btb_q.pc;
   assign bus.btb_update_target = btb_q.target;

   perf_counter #(.CNT_W(CNT_W)) u_cnt_branches (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (resolve),
      .count_o (bus.cnt_branches)
   );

   perf_counter #(.CNT_W(CNT_W)) u_cnt_mispredicts (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (mispredict),
      .count_o (bus.cnt_mispredicts)
   );

endmodule

// File: tb/tb_branch_resolve.sv
// Directed-vector bench for branch_resolve: a default instance for the main
// scenarios and a 4-bit-counter instance for the wrap case.
module tb_branch_resolve;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_passed;

   branch_resolve_if #(.CNT_W(32)) bus ();
   branch_resolve_if #(.CNT_W(4))  wbus ();

   branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (wbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_passed++;
         $display("check %-18s got=%0h exp=%0h ok", tag, got, exp);
      end else begin
         $display("FAIL %-18s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // valid, is_branch, is_jump, pc, pred_hit, pred_target, taken, target, stall
   task automatic drive(input logic v, input logic br, input logic jmp,
                        input logic [31:0] pc, input logic hit, input logic [31:0] pt,
                        input logic tk, input logic [31:0] tgt, input logic stall);
      bus.ex_valid       = v;
      bus.ex_is_branch   = br;
      bus.ex_is_jump     = jmp;
      bus.ex_pc          = pc;
      bus.ex_pred_hit    = hit;
      bus.ex_pred_target = pt;
      bus.ex_taken       = tk;
      bus.ex_target      = tgt;
      bus.ex_stall       = stall;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic rv, input logic [31:0] rpc,
                            input logic ben, input logic [31:0] bpc, input logic [31:0] btg,
                            input logic [31:0] nbr, input logic [31:0] nmp);
      check({tag, ".rv"},   bus.redirect_valid, rv);
      check({tag, ".rpc"},  bus.redirect_pc, rpc);
      check({tag, ".ben"},  bus.btb_update_en, ben);
      check({tag, ".bpc"},  bus.btb_update_pc, bpc);
      check({tag, ".btg"},  bus.btb_update_target, btg);
      check({tag, ".nbr"},  bus.cnt_branches, nbr);
      check({tag, ".nmp"},  bus.cnt_mispredicts, nmp);
   endtask

   initial begin
      n_checks = 0;
      n_passed = 0;
      rst = 1'b1;
      idle();
      wbus.ex_valid = 1'b0; wbus.ex_stall = 1'b0; wbus.ex_is_branch = 1'b0;
      wbus.ex_is_jump = 1'b0; wbus.ex_pc = '0; wbus.ex_pred_hit = 1'b0;
      wbus.ex_pred_target = '0; wbus.ex_taken = 1'b0; wbus.ex_target = '0;
      repeat (2) tick();
      check_out("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
      rst = 1'b0;
      tick();

      // Pred taken, actually not taken -> fall-through redirect, no BTB write.
      drive(1, 1, 0, 32'h100, 1, 32'h200, 0, 32'h200, 0);
      tick();
      check_out("dir_nt", 1, 32'h104, 0, 32'h0, 32'h0, 1, 1);
      idle();
      tick();
      check_out("dir_nt.pulse", 0, 32'h104, 0, 32'h0, 32'h0, 1, 1);
      tick();

      // Cold jal: redirect and BTB write in the same cycle.
      drive(1, 0, 1, 32'h2000, 0, 32'h0, 0, 32'h3000, 0);
      tick();
      check_out("cold_jal", 1, 32'h3000, 1, 32'h2000, 32'h3000, 2, 2);
      idle();
      tick();
      check_out("cold_jal.hold", 0, 32'h3000, 0, 32'h2000, 32'h3000, 2, 2);
      tick();

      // Correctly predicted taken branch.
      drive(1, 1, 0, 32'h400, 1, 32'h480, 1, 32'h480, 0);
      tick();
      check_out("correct", 0, 32'h3000, 0, 32'h2000, 32'h3000, 3, 2);

      // Shadow masking: mispredict at N, wrong-path mispredicts at N+1, N+2 ignored.
      drive(1, 1, 0, 32'h500, 0, 32'h0, 1, 32'h600, 0);
      tick();
      check_out("shadow.N", 1, 32'h600, 1, 32'h500, 32'h600, 4, 3);
      drive(1, 1, 0, 32'h700, 0, 32'h0, 1, 32'h800, 0);
      tick();
      check_out("shadow.N1", 0, 32'h600, 0, 32'h500, 32'h600, 4, 3);
      tick();
      check_out("shadow.N2", 0, 32'h600, 0, 32'h500, 32'h600, 4, 3);
      tick();
      check_out("shadow.N3", 1, 32'h800, 1, 32'h700, 32'h800, 5, 4);
      idle();
      tick();
      tick();

      // Both taken, wrong target.
      drive(1, 1, 0, 32'h900, 1, 32'hA00, 1, 32'hA40, 0);
      tick();
      check_out("tgt", 1, 32'hA40, 1, 32'h900, 32'hA40, 6, 5);
      idle();
      tick();
      tick();

      // Stall: a held mispredict resolves once, on release.
      drive(1, 1, 0, 32'hB00, 1, 32'hC00, 0, 32'hC00, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall.rv", bus.redirect_valid, 1'b0);
      end
      bus.ex_stall = 1'b0;
      tick();
      check_out("stall.rel", 1, 32'hB04, 0, 32'h900, 32'hA40, 7, 6);
      idle();
      tick();
      check("stall.once", bus.redirect_valid, 1'b0);
      tick();

      // Reset mid-shadow, then a resolve right after release is processed.
      drive(1, 0, 1, 32'hD00, 0, 32'h0, 0, 32'hE00, 0);
      tick();
      check_out("rst.pre", 1, 32'hE00, 1, 32'hD00, 32'hE00, 8, 7);
      rst = 1'b1;
      #1;
      check_out("rst.mid", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
      rst = 1'b0;
      drive(1, 1, 0, 32'hF00, 0, 32'h0, 1, 32'hF80, 0);
      tick();
      check_out("rst.post", 1, 32'hF80, 1, 32'hF00, 32'hF80, 1, 1);
      idle();

      // 16 correctly predicted not-taken branches wrap a 4-bit counter.
      wbus.ex_valid = 1'b1;
      wbus.ex_is_branch = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 14) check("wrap.15", wbus.cnt_branches, 64'd15);
      end
      wbus.ex_valid = 1'b0;
      tick();
      check("wrap.0", wbus.cnt_branches, 64'd0);
      check("wrap.nmp", wbus.cnt_mispredicts, 64'd0);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

EX-stage branch resolution unit: the writer side of the direct-mapped BTB that IF queries each cycle. It compares the prediction carried down the pipeline against the resolved outcome of each branch or jump. From that comparison it emits a registered PC redirect, masks wrong-path instructions during a fixed flush shadow, and drives the BTB write port. Sits between the EX datapath and the BTB `update_en/pc_ex/target_ex` inputs; also keeps branch and mispredict performance counters.

## Interface
- `FLUSH_CYCLES`, 2: shadow length in cycles after a mispredict (≥1).
- `CNT_W`, 32: performance counter width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_stall` in 1: EX held this cycle; the instruction has not left EX.
- `ex_is_branch` in 1: conditional branch.
- `ex_is_jump` in 1: jal/jalr (always taken).
- `ex_pc` in 32: instruction PC.
- `ex_pred_hit` in 1: IF BTB hit, i.e. predicted taken.
- `ex_pred_target` in 32: target predicted in IF.
- `ex_taken` in 1: resolved direction (conditional branches only).
- `ex_target` in 32: resolved target; bit 0 is already cleared upstream.
- `redirect_valid` out 1: one-cycle pulse; IF must fetch `redirect_pc`, and younger stages flush.
- `redirect_pc` out 32: corrected fetch PC.
- `btb_update_en` out 1: BTB write strobe.
- `btb_update_pc` out 32: BTB write PC.
- `btb_update_target` out 32: BTB write target.
- `cnt_branches` out CNT_W: resolved branches and jumps.
- `cnt_mispredicts` out CNT_W: mispredicts.

## Operation
- **Resolve event.** `ex_valid && !ex_stall && (ex_is_branch || ex_is_jump) && state==RUN`.
  - Held (stalled) instructions resolve exactly once, on their leaving cycle.
  - Non-branch instructions are ignored.
- **Actual taken.** `act_taken = ex_is_jump | ex_taken`. When both type flags are set, the instruction is treated as a jump.
- **Mispredict classes:**
  - pred taken, act not-taken → redirect to `ex_pc + 32'd4` (modulo 2^32).
  - pred not-taken, act taken → redirect to `ex_target`.
  - both taken, `ex_pred_target != ex_target` → redirect to `ex_target`.
  - otherwise correct; no redirect.
- **BTB write.** Issued when `act_taken && (!ex_pred_hit || ex_pred_target != ex_target)`, carrying `ex_pc` and `ex_target`. A not-taken branch never writes; the BTB has no invalidate port, so a stale entry stays until overwritten.
- **FSM states:**
  - RUN: resolve events are processed. A mispredict moves the FSM to SHADOW and loads the shadow counter with `FLUSH_CYCLES-1`.
  - SHADOW: all EX inputs are ignored (wrong path). No redirect, no BTB write, no counting. The counter decrements each cycle; on the cycle it reads 0 the FSM returns to RUN for the next cycle.
- **Counters.**
  - `cnt_branches` increments on every resolve event.
  - `cnt_mispredicts` increments on mispredicts.
  - Both wrap modulo 2^CNT_W.

## Timing
- **Output latency.** All outputs are registered. Redirect and BTB write appear in cycle N+1 for a resolve in cycle N, both as single-cycle pulses.
- **Redirect/update data.** `redirect_pc`, `btb_update_pc` and `btb_update_target` hold their last value when the matching strobe is low.
- **Shadow window.** Covers cycles N+1 through N+FLUSH_CYCLES inclusive. With default 2, the earliest new resolve is at N+3.
- **Same-entry refresh.** A BTB write issued at N+1 is visible to an IF lookup at N+2. An IF lookup of the same PC at N+1 still sees the old entry; this is accepted.
- **Reset values.** All outputs are 0, the counters are 0, and state is RUN. `rst` asserted during SHADOW returns the FSM to RUN immediately and drops any pending redirect or update.
- **Stall.** `ex_stall` has no effect in SHADOW; the shadow counter still decrements.
- **Simultaneous mispredict and BTB write.** A mispredict that also requires a BTB write produces both pulses in the same cycle.

## Structure
- **Shared package `bp_pkg`:**
  - `XLEN=32`.
  - `resolve_state_e` {RUN, SHADOW}.
  - `mispredict_e` {MP_NONE, MP_DIR_NT, MP_DIR_T, MP_TGT}.
  - `btb_update_t` struct {en, pc, target}, reused by the BTB side.
- **Sub-module.** One sub-module, `perf_counter`: CNT_W wrapping counter with increment enable and async reset. Instantiated twice.

## Test plan
- **Mispredict, pred taken / act not-taken.** Reset, then resolve a branch with pc=0x100, pred_hit=1, pred_target=0x200, taken=0.
  - Next cycle: redirect_valid=1, redirect_pc=0x104, btb_update_en=0.
  - Counters: mispredicts=1, branches=1.
- **Cold jal.** Resolve a jal with pc=0x2000, pred_hit=0, target=0x3000.
  - Next cycle: redirect to 0x3000, btb_update_en=1 with pc 0x2000 and target 0x3000.
- **Correct prediction.** Resolve a branch with pc=0x400, pred_hit=1, pred_target=0x480, taken=1, target=0x480.
  - No redirect, no BTB write; branches increments by 1.
- **Shadow masking.** Mispredict at cycle N; then present valid mispredicting branches at N+1 and N+2.
  - Both are ignored: no redirect, counters unchanged.
  - The same stimulus at N+3 is processed.
- **Stall.** Hold a mispredicting branch with ex_stall=1 for 3 cycles, then release.
  - Exactly one redirect, asserted the cycle after release; mispredicts=1.
- **Reset mid-shadow and wrap.**
  - Assert rst during SHADOW: all outputs 0, and a resolve in the cycle right after rst deasserts is processed.
  - With CNT_W=4, 16 resolves wrap cnt_branches to 0.
